// File: rtl/instr_decode_pipe.sv
// Instruction decoder feeding a DEPTH-entry output queue with an illegal-word counter.
// Optional extended opcode set enabled by defining DECODE_EXT_EN.
module instr_decode_pipe #(
   parameter int unsigned CODE_W = 5,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [31:0]       in_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] out_code,
   output logic              out_illegal,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc,
   output logic [15:0]       illegal_cnt
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic              illegal;
      logic [31:0]       instr;
      logic [31:0]       pc;
   } entry_t;

   logic [5:0]       op;
   logic [5:0]       funct;
   logic [4:0]       code_n;
   entry_t           dec;
   entry_t           head;
   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   assign op    = in_instr[31:26];
   assign funct = in_instr[5:0];

   // Code 0 means unrecognised; every path starts from that default.
   always_comb begin
      code_n = 5'd0;
      case (op)
         6'b000000: begin
            case (funct)
               6'b100001: code_n = 5'd1;
               6'b100011: code_n = 5'd2;
               6'b001000: code_n = 5'd3;
               6'b000000: code_n = 5'd4;
`ifdef DECODE_EXT_EN
               6'b100000: code_n = 5'd11;
               6'b100010: code_n = 5'd12;
               6'b100100: code_n = 5'd13;
               6'b100101: code_n = 5'd14;
               6'b101010: code_n = 5'd15;
`endif
               default:   code_n = 5'd0;
            endcase
         end
         6'b001101: code_n = 5'd5;
         6'b100011: code_n = 5'd6;
         6'b101011: code_n = 5'd7;
         6'b000100: code_n = 5'd8;
         6'b001111: code_n = 5'd9;
         6'b000011: code_n = 5'd10;
`ifdef DECODE_EXT_EN
         6'b000101: code_n = 5'd16;
         6'b000010: code_n = 5'd17;
         6'b001001: code_n = 5'd18;
`endif
         default:   code_n = 5'd0;
      endcase
   end

   always_comb begin
      dec.code    = CODE_W'(code_n);
      dec.illegal = (code_n == 5'd0);
      dec.instr   = in_instr;
      dec.pc      = in_pc;
   end

   assign in_ready  = (count < CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   // Head entry is masked to zero while the queue is empty.
   assign head        = mem[rd_ptr];
   assign out_code    = out_valid ? head.code    : '0;
   assign out_illegal = out_valid ? head.illegal : 1'b0;
   assign out_instr   = out_valid ? head.instr   : '0;
   assign out_pc      = out_valid ? head.pc      : '0;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= dec;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         illegal_cnt <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (push && dec.illegal && (illegal_cnt != 16'hFFFF))
            illegal_cnt <= illegal_cnt + 16'd1;
      end
   end

endmodule
